contador_param: RTL and testbench



---
 rtl/contador_param.sv | 101 ++++++++++
 tb/tb_contador_param.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/contador_param.sv
`timescale 1ns/1ps
// contador_param: parametrised up/down counter with range 0..MAX.
// Each clock edge applies one action, in priority order: clear, load, count,
// hold. At a boundary the counter either wraps or saturates, depending on
// SATURATE. A boundary event drives a one-cycle registered pulse on tc and
// sets the sticky ovf flag.
//
// Parameters:
//   WIDTH    counter width in bits (2..32)
//   MAX      terminal count value (1..2**WIDTH-1)
//   SATURATE 0 = wrap at the boundary, 1 = hold at the boundary
//
// Ports:
//   clk    in   clock, rising edge
//   reset  in   asynchronous, active-high reset
//   en     in   count enable
//   mdir   in   direction: 0 counts up, 1 counts down
//   load   in   synchronous load of din (the value is clamped to MAX)
//   din    in   load value
//   clear  in   synchronous clear of cont, tc and ovf
//   cont   out  registered count value
//   tc     out  registered terminal-count pulse
//   ovf    out  sticky boundary flag
//   zero   out  combinational (cont == 0)
module contador_param #(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned MAX      = (2**WIDTH) - 1,
    parameter int unsigned SATURATE = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             mdir,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             clear,
    output logic [WIDTH-1:0] cont,
    output logic             tc,
    output logic             ovf,
    output logic             zero
);

    localparam logic [WIDTH-1:0] MAX_V  = MAX[WIDTH-1:0];
    localparam logic [WIDTH-1:0] ZERO_V = '0;
    localparam logic [WIDTH-1:0] ONE_V  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam bit               SAT    = (SATURATE != 0);

    logic [WIDTH-1:0] cont_q, cont_d;
    logic             tc_q, tc_d;
    logic             ovf_q, ovf_d;

    // Boundary detection depends only on the current value and the direction.
    logic at_top, at_bottom, boundary;
    logic [WIDTH-1:0] up_val, down_val, din_clamped;

    always_comb begin
        at_top      = (cont_q == MAX_V);
        at_bottom   = (cont_q == ZERO_V);
        boundary    = mdir ? at_bottom : at_top;
        // At a boundary, wrap lands on the opposite end and saturate stays put.
        up_val      = at_top    ? (SAT ? MAX_V : ZERO_V) : (cont_q + ONE_V);
        down_val    = at_bottom ? (SAT ? ZERO_V : MAX_V) : (cont_q - ONE_V);
        din_clamped = (din > MAX_V) ? MAX_V : din;
    end

    always_comb begin
        cont_d = cont_q;
        tc_d   = 1'b0;
        ovf_d  = ovf_q;
        if (clear) begin
            cont_d = ZERO_V;
            ovf_d  = 1'b0;
        end else if (load) begin
            cont_d = din_clamped;
        end else if (en) begin
            cont_d = mdir ? down_val : up_val;
            if (boundary) begin
                tc_d  = 1'b1;
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cont_q <= ZERO_V;
            tc_q   <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            cont_q <= cont_d;
            tc_q   <= tc_d;
            ovf_q  <= ovf_d;
        end
    end

    assign cont = cont_q;
    assign tc   = tc_q;
    assign ovf  = ovf_q;
    assign zero = (cont_q == ZERO_V);

endmodule

// File: tb/tb_contador_param.sv
`timescale 1ns/1ps
// Scoreboard bench for contador_param. Three instances share the same stimulus:
//   0: WIDTH=4 MAX=9  wrap
//   1: WIDTH=4 MAX=9  saturate
//   2: WIDTH=4 MAX=15 wrap (natural modulo 16)
// For every driven cycle, the driver pushes the model's expected outputs into a
// queue. The monitor pops these entries after each rising edge and compares them.
module tb_contador_param;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       en = 1'b0, mdir = 1'b0, load = 1'b0, clear = 1'b0;
    logic [3:0] din = 4'd0;

    logic [3:0] cont_w, cont_s, cont_f;
    logic       tc_w, tc_s, tc_f, ovf_w, ovf_s, ovf_f, zero_w, zero_s, zero_f;

    always #50 clk = ~clk;

    contador_param #(.WIDTH(4), .MAX(9), .SATURATE(0)) u_wrap (
        .clk(clk), .reset(reset), .en(en), .mdir(mdir), .load(load), .din(din),
        .clear(clear), .cont(cont_w), .tc(tc_w), .ovf(ovf_w), .zero(zero_w));

    contador_param #(.WIDTH(4), .MAX(9), .SATURATE(1)) u_sat (
        .clk(clk), .reset(reset), .en(en), .mdir(mdir), .load(load), .din(din),
        .clear(clear), .cont(cont_s), .tc(tc_s), .ovf(ovf_s), .zero(zero_s));

    contador_param #(.WIDTH(4)) u_full (
        .clk(clk), .reset(reset), .en(en), .mdir(mdir), .load(load), .din(din),
        .clear(clear), .cont(cont_f), .tc(tc_f), .ovf(ovf_f), .zero(zero_f));

    typedef struct {
        int dut;
        int cnt;
        bit tc;
        bit ovf;
    } exp_t;

    exp_t sb[$];

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state per instance.
    int max_v[3] = '{9, 9, 15};
    bit sat_v[3] = '{1'b0, 1'b1, 1'b0};
    int m_cnt[3];
    bit m_ovf[3];

    task automatic check(input string name, input int dut, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s dut%0d at %0t: got %0d expected %0d", name, dut, $time, got, exp);
        end
    endtask

    function automatic int get_cont(input int d);
        case (d)
            0:       return int'(cont_w);
            1:       return int'(cont_s);
            default: return int'(cont_f);
        endcase
    endfunction

    function automatic int get_tc(input int d);
        case (d)
            0:       return int'(tc_w);
            1:       return int'(tc_s);
            default: return int'(tc_f);
        endcase
    endfunction

    function automatic int get_ovf(input int d);
        case (d)
            0:       return int'(ovf_w);
            1:       return int'(ovf_s);
            default: return int'(ovf_f);
        endcase
    endfunction

    function automatic int get_zero(input int d);
        case (d)
            0:       return int'(zero_w);
            1:       return int'(zero_s);
            default: return int'(zero_f);
        endcase
    endfunction

    // Drive one cycle of inputs and queue what each instance should show after
    // the next rising edge. The model works in plain integer arithmetic.
    task automatic step(input bit c, input bit l, input bit e, input bit d, input int v);
        @(negedge clk);
        clear = c;
        load  = l;
        en    = e;
        mdir  = d;
        din   = 4'(v);
        for (int i = 0; i < 3; i++) begin
            exp_t x;
            int   n;
            bit   t;
            t = 1'b0;
            if (c) begin
                m_cnt[i] = 0;
                m_ovf[i] = 1'b0;
            end else if (l) begin
                m_cnt[i] = (v > max_v[i]) ? max_v[i] : v;
            end else if (e) begin
                n = d ? m_cnt[i] - 1 : m_cnt[i] + 1;
                if (n > max_v[i] || n < 0) begin
                    t = 1'b1;
                    m_ovf[i] = 1'b1;
                    if (sat_v[i]) n = (n < 0) ? 0 : max_v[i];
                    else          n = (n < 0) ? n + max_v[i] + 1 : n - max_v[i] - 1;
                end
                m_cnt[i] = n;
            end
            x.dut = i;
            x.cnt = m_cnt[i];
            x.tc  = t;
            x.ovf = m_ovf[i];
            sb.push_back(x);
        end
    endtask

    task automatic check_reset_state(input string tag);
        for (int i = 0; i < 3; i++) begin
            check({tag, "_cont"}, i, get_cont(i), 0);
            check({tag, "_tc"},   i, get_tc(i), 0);
            check({tag, "_ovf"},  i, get_ovf(i), 0);
            check({tag, "_zero"}, i, get_zero(i), 1);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_cnt[i] = 0;
            m_ovf[i] = 1'b0;
        end
    endtask

    // Assert reset between edges (after the pending edge has been checked).
    // The outputs must clear at once, with no clock edge in between.
    task automatic mid_cycle_reset();
        @(posedge clk);
        #10;
        reset = 1'b1;
        #1;
        check_reset_state("async_reset");
        @(posedge clk);
        #20;
        reset = 1'b0;
        model_reset();
    endtask

    // Monitor: after each edge, pop one entry per instance and compare it.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            while (sb.size() > 0) begin
                exp_t x;
                x = sb.pop_front();
                check("cont", x.dut, get_cont(x.dut), x.cnt);
                check("tc",   x.dut, get_tc(x.dut),   int'(x.tc));
                check("ovf",  x.dut, get_ovf(x.dut),  int'(x.ovf));
                check("zero", x.dut, get_zero(x.dut), (x.cnt == 0) ? 1 : 0);
            end
        end
    end

    initial begin
        model_reset();
        // Reset from 10 ns to 70 ns; the first count happens at the 150 ns edge.
        #10;
        reset = 1'b1;
        #1;
        check_reset_state("reset");
        #59;
        reset = 1'b0;

        // Count up through the boundary.
        for (int k = 0; k < 11; k++) step(1'b0, 1'b0, 1'b1, 1'b0, 0);
        // Clear, then count down through the boundary twice.
        step(1'b1, 1'b0, 1'b0, 1'b0, 0);
        for (int k = 0; k < 11; k++) step(1'b0, 1'b0, 1'b1, 1'b1, 0);
        // Load 7, count up into the top boundary, then turn around.
        step(1'b0, 1'b1, 1'b0, 1'b0, 7);
        for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 1'b1, 1'b0, 0);
        step(1'b0, 1'b0, 1'b1, 1'b1, 0);
        // A load takes priority over en; an out-of-range din is clamped.
        step(1'b0, 1'b1, 1'b1, 1'b0, 14);
        step(1'b0, 1'b1, 1'b1, 1'b0, 5);
        // With ovf set, clear wins over load.
        step(1'b0, 1'b1, 1'b0, 1'b0, 9);
        step(1'b0, 1'b0, 1'b1, 1'b0, 0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 6);
        step(1'b1, 1'b1, 1'b1, 1'b0, 3);
        // Reset mid-count at 4, then resume counting.
        for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 1'b1, 1'b0, 0);
        mid_cycle_reset();
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 1'b1, 1'b0, 0);

        // Randomised traffic.
        for (int k = 0; k < 400; k++) begin
            step(($urandom_range(0, 15) == 0), ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                 int'($urandom_range(0, 15)));
        end
        step(1'b0, 1'b0, 1'b0, 1'b0, 0);

        // Drain the scoreboard, with a bounded wait.
        begin
            int budget;
            budget = 10;
            while (sb.size() > 0 && budget > 0) begin
                @(posedge clk);
                #2;
                budget--;
            end
            n_checks++;
            if (sb.size() != 0) begin
                n_errors++;
                $display("FAIL drain: %0d entries left, expected 0", sb.size());
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
